drum_voice_gen: RTL

- Downstream of the pattern datapath. On each sequencer step strobe it samples the four per-instrument hit bits (ins1..ins4) and fires one voice per set bit.
- Each fired voice produces a fixed-length gate pulse and a square-wave tone at its own pitch.
- A registered popcount mix of the four tones drives a simple resistor-ladder or GPIO audio output.
- The gates also drive the per-instrument LEDs.

---
 rtl/drum_voice_gen_if.sv | 36 +++
 rtl/drum_voice_gen.sv | 139 +++++++++++++
 2 files changed

// File: rtl/drum_voice_gen_if.sv
// Bundle of the control inputs and audio/LED outputs of drum_voice_gen.
//   enable : play mode, low = silence
//   step   : one-cycle sequencer step strobe
//   hits   : per-instrument hit bits, valid with step
//   accent : per-instrument accent bits, valid with step (only with ACCENT_EN)
//   gate   : per-voice gate, tone : per-voice square wave
//   mix    : registered popcount of tone, busy : OR of gate
// Optional feature macro: ACCENT_EN (adds the accent signal).
interface drum_voice_gen_if;
    logic       enable;
    logic       step;
    logic [3:0] hits;
`ifdef ACCENT_EN
    logic [3:0] accent;
`endif
    logic [3:0] gate;
    logic [3:0] tone;
    logic [2:0] mix;
    logic       busy;

    modport master (
`ifdef ACCENT_EN
        output accent,
`endif
        output enable, step, hits,
        input  gate, tone, mix, busy
    );

    modport slave (
`ifdef ACCENT_EN
        input  accent,
`endif
        input  enable, step, hits,
        output gate, tone, mix, busy
    );
endinterface

// File: rtl/drum_voice_gen.sv
// Four-voice drum trigger: each hit sampled on a step strobe starts a
// fixed-length gate and a square tone at that voice's pitch; a registered
// popcount of the tones forms a crude 3-bit audio mix.
// Ports:
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : drum_voice_gen_if.slave (enable, step, hits[, accent] in;
//           gate, tone, mix, busy out)
// Optional feature macro: ACCENT_EN -- accented hits get a double-length gate.

// One voice: gate down-counter plus tone half-period phase counter.
module drum_voice #(
    parameter int unsigned GATE_CYCLES = 2500000,
    parameter int unsigned CNT_W       = 23,
    parameter int unsigned TONE_DIV    = 47800,
    parameter int unsigned DIV_W       = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic trig,     // step & hit for this voice
    input  logic accent,
    output logic gate,
    output logic tone
);
    logic             active_q, active_d;
    logic             tone_q, tone_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] phase_q, phase_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_q <= 1'b0;
            tone_q   <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= '0;
        end else begin
            active_q <= active_d;
            tone_q   <= tone_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    always_comb begin
        active_d = active_q;
        tone_d   = tone_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        if (!enable) begin
            // enable low beats any simultaneous step
            active_d = 1'b0;
            tone_d   = 1'b0;
            cnt_d    = '0;
            phase_d  = '0;
        end else if (trig) begin
            // (re)trigger: reload gate and restart tone high
            active_d = 1'b1;
            tone_d   = 1'b1;
            cnt_d    = accent ? CNT_W'(2*GATE_CYCLES-1) : CNT_W'(GATE_CYCLES-1);
            phase_d  = '0;
        end else if (active_q) begin
            if (cnt_q == '0) begin
                active_d = 1'b0;
                tone_d   = 1'b0;
                phase_d  = '0;
            end else begin
                cnt_d = cnt_q - 1'b1;
                if (phase_q == DIV_W'(TONE_DIV-1)) begin
                    phase_d = '0;
                    tone_d  = ~tone_q;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
        end
    end

    assign gate = active_q;
    assign tone = tone_q;
endmodule

module drum_voice_gen #(
    parameter int unsigned GATE_CYCLES = 2500000,
    parameter int unsigned CNT_W       = 23,
    parameter int unsigned TONE_DIV0   = 47800,
    parameter int unsigned TONE_DIV1   = 37900,
    parameter int unsigned TONE_DIV2   = 28400,
    parameter int unsigned TONE_DIV3   = 18900,
    parameter int unsigned DIV_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    drum_voice_gen_if.slave   bus
);
    logic [3:0] gate_w, tone_w, acc_w;
    logic [2:0] mix_q, mix_d;

`ifdef ACCENT_EN
    assign acc_w = bus.accent;
`else
    assign acc_w = 4'b0000;
`endif

    for (genvar i = 0; i < 4; i++) begin : g_voice
        localparam int unsigned TDIV = (i == 0) ? TONE_DIV0 :
                                       (i == 1) ? TONE_DIV1 :
                                       (i == 2) ? TONE_DIV2 : TONE_DIV3;
        drum_voice #(
            .GATE_CYCLES (GATE_CYCLES),
            .CNT_W       (CNT_W),
            .TONE_DIV    (TDIV),
            .DIV_W       (DIV_W)
        ) u_voice (
            .clk    (clk),
            .reset  (reset),
            .enable (bus.enable),
            .trig   (bus.step & bus.hits[i]),
            .accent (acc_w[i]),
            .gate   (gate_w[i]),
            .tone   (tone_w[i])
        );
    end

    always_comb begin
        mix_d = '0;
        for (int k = 0; k < 4; k++) mix_d = mix_d + 3'(tone_w[k]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mix_q <= '0;
        else        mix_q <= mix_d;
    end

    assign bus.gate = gate_w;
    assign bus.tone = tone_w;
    assign bus.mix  = mix_q;
    assign bus.busy = |gate_w;
endmodule
